// File: rtl/chess_clock_tick_sched.sv
// chess_clock_tick_sched
// Time base for a two-player chess clock: prescaled decrement strobes routed to
// the side on move, turn handover with Fischer bonus bursts, pause/resume and
// flag-fall detection. All outputs are registered; strobes are one cycle wide.
// Build option: define CHESS_CLOCK_DELAY_EN to suppress the first p_delay ticks
// after each turn start (US delay). Without it, p_delay is unused.
module chess_clock_tick_sched #(
   parameter int unsigned p_divider = 50_000_000,
   parameter int unsigned p_incr    = 2,
   parameter int unsigned p_gap     = 4,
   parameter int unsigned p_delay   = 3
) (
   input  logic       i_clk_50m,
   input  logic       i_rst,
   input  logic       i_restart,
   input  logic       i_stop,
   input  logic       i_turn_a,
   input  logic       i_turn_b,
   input  logic       i_zero_a,
   input  logic       i_zero_b,
   output logic       o_tick_a,
   output logic       o_tick_b,
   output logic       o_add_a,
   output logic       o_add_b,
   output logic [1:0] o_active,
   output logic       o_paused,
   output logic       o_win_a,
   output logic       o_win_b
);

   localparam int unsigned PW = $clog2(p_divider);
   localparam int unsigned AW = $clog2(p_incr + 2);
   localparam int unsigned GW = $clog2(p_gap + 1);

   localparam logic [PW-1:0] PRESC_MAX  = PW'(p_divider - 1);
   localparam logic [AW-1:0] ADD_LAST   = AW'(p_incr);
   localparam logic [GW-1:0] GAP_RELOAD = GW'(p_gap - 1);

   typedef enum logic [2:0] {
      IDLE,
      RUN_A,
      RUN_B,
      INCR,
      PAUSE,
      OVER
   } state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] presc, presc_nxt;
   // side: mover while in INCR, side to resume while in PAUSE (0 = A, 1 = B)
   logic          side, side_nxt;
   logic [AW-1:0] add_cnt, add_nxt;
   logic [GW-1:0] gap_cnt, gap_nxt;
   logic          pend, pend_nxt;

   logic          tick_a_nxt, tick_b_nxt, add_a_nxt, add_b_nxt;
   logic [1:0]    active_nxt;
   logic          paused_nxt, win_a_nxt, win_b_nxt;

   logic          zero_cur, turn_cur, wrap, fire;
   logic          run_load, run_wrap, hold_tick;

   assign wrap = (presc == PRESC_MAX);

   // Next-state, datapath and output decode with priority restart > zero > stop > turn
   always_comb begin
      state_nxt  = state;
      presc_nxt  = presc;
      side_nxt   = side;
      add_nxt    = add_cnt;
      gap_nxt    = gap_cnt;
      pend_nxt   = pend;
      win_a_nxt  = o_win_a;
      win_b_nxt  = o_win_b;
      tick_a_nxt = 1'b0;
      tick_b_nxt = 1'b0;
      add_a_nxt  = 1'b0;
      add_b_nxt  = 1'b0;
      fire       = 1'b0;
      run_load   = 1'b0;
      run_wrap   = 1'b0;
      zero_cur   = (state == RUN_B) ? i_zero_b : i_zero_a;
      turn_cur   = (state == RUN_B) ? i_turn_b : i_turn_a;

      if (i_restart) begin
         state_nxt = IDLE;
         presc_nxt = '0;
         side_nxt  = 1'b0;
         add_nxt   = '0;
         gap_nxt   = '0;
         pend_nxt  = 1'b0;
         win_a_nxt = 1'b0;
         win_b_nxt = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_turn_b && !i_turn_a) begin
                  state_nxt = RUN_A;
                  side_nxt  = 1'b0;
                  presc_nxt = '0;
                  run_load  = 1'b1;
               end else if (i_turn_a && !i_turn_b) begin
                  state_nxt = RUN_B;
                  side_nxt  = 1'b1;
                  presc_nxt = '0;
                  run_load  = 1'b1;
               end
            end
            RUN_A, RUN_B: begin
               if (zero_cur) begin
                  state_nxt = OVER;
                  if (state == RUN_A) win_b_nxt = 1'b1;
                  else                win_a_nxt = 1'b1;
               end else if (i_stop) begin
                  state_nxt = PAUSE;
                  side_nxt  = (state == RUN_B);
               end else if (turn_cur) begin
                  state_nxt = INCR;
                  side_nxt  = (state == RUN_B);
                  presc_nxt = '0;
                  add_nxt   = '0;
                  gap_nxt   = '0;
                  pend_nxt  = 1'b0;
               end else begin
                  run_wrap  = wrap;
                  presc_nxt = wrap ? '0 : presc + 1'b1;
                  fire      = wrap & ~hold_tick;
               end
            end
            INCR: begin
               if (add_cnt == ADD_LAST) begin
                  // a stop on the exit cycle itself still lands in PAUSE
                  state_nxt = (pend || i_stop) ? PAUSE : (side ? RUN_A : RUN_B);
                  side_nxt  = ~side;
                  presc_nxt = '0;
                  pend_nxt  = 1'b0;
                  run_load  = 1'b1;
               end else begin
                  pend_nxt = pend | i_stop;
                  if (gap_cnt == '0) begin
                     add_a_nxt = ~side;
                     add_b_nxt = side;
                     add_nxt   = add_cnt + 1'b1;
                     gap_nxt   = GAP_RELOAD;
                  end else begin
                     gap_nxt = gap_cnt - 1'b1;
                  end
               end
            end
            PAUSE: begin
               if (i_stop) state_nxt = side ? RUN_B : RUN_A;
            end
            OVER: begin
               state_nxt = OVER;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end

      tick_a_nxt = fire & (state == RUN_A);
      tick_b_nxt = fire & (state == RUN_B);
      active_nxt = {state_nxt == RUN_B, state_nxt == RUN_A};
      paused_nxt = (state_nxt == PAUSE);
   end

   // FSM state register
   always_ff @(posedge i_clk_50m or negedge i_rst) begin
      if (!i_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   // Prescaler, bonus-burst bookkeeping and registered outputs
   always_ff @(posedge i_clk_50m or negedge i_rst) begin
      if (!i_rst) begin
         presc    <= '0;
         side     <= 1'b0;
         add_cnt  <= '0;
         gap_cnt  <= '0;
         pend     <= 1'b0;
         o_tick_a <= 1'b0;
         o_tick_b <= 1'b0;
         o_add_a  <= 1'b0;
         o_add_b  <= 1'b0;
         o_active <= '0;
         o_paused <= 1'b0;
         o_win_a  <= 1'b0;
         o_win_b  <= 1'b0;
      end else begin
         presc    <= presc_nxt;
         side     <= side_nxt;
         add_cnt  <= add_nxt;
         gap_cnt  <= gap_nxt;
         pend     <= pend_nxt;
         o_tick_a <= tick_a_nxt;
         o_tick_b <= tick_b_nxt;
         o_add_a  <= add_a_nxt;
         o_add_b  <= add_b_nxt;
         o_active <= active_nxt;
         o_paused <= paused_nxt;
         o_win_a  <= win_a_nxt;
         o_win_b  <= win_b_nxt;
      end
   end

`ifdef CHESS_CLOCK_DELAY_EN
   localparam int unsigned   DW       = $clog2(p_delay + 2);
   localparam logic [DW-1:0] DLY_INIT = DW'(p_delay);

   logic [DW-1:0] dly;

   // Delay budget: reloaded at each turn start (held through pause), one wrap spent at a time
   always_ff @(posedge i_clk_50m or negedge i_rst) begin
      if (!i_rst)                     dly <= '0;
      else if (i_restart)             dly <= '0;
      else if (run_load)              dly <= DLY_INIT;
      else if (run_wrap && hold_tick) dly <= dly - 1'b1;
   end

   assign hold_tick = (dly != '0);
`else
   logic unused_cfg;

   assign hold_tick  = 1'b0;
   assign unused_cfg = ^{run_load, run_wrap, (p_delay == 0)};
`endif

endmodule

// File: tb/tb_chess_clock_tick_sched.sv
// Bench for chess_clock_tick_sched with p_divider=10, p_incr=2, p_gap=4, p_delay=3.
// A behavioural model (elapsed-cycle arithmetic per game phase) is checked against
// every output on every falling edge; directed scenarios add literal expectations.
module tb_chess_clock_tick_sched;

   localparam int DIV = 10;
   localparam int INC = 2;
   localparam int GAP = 4;
   localparam int DLY = 3;
`ifdef CHESS_CLOCK_DELAY_EN
   localparam int DLYN = DLY;
`else
   localparam int DLYN = 0;
`endif
   localparam int FIRST     = (DLYN + 1) * DIV;
   localparam int INCR_EXIT = (INC == 0) ? 1 : (INC - 1) * GAP + 2;

   logic       clk     = 1'b0;
   logic       rst     = 1'b0;
   logic       restart = 1'b0;
   logic       stop    = 1'b0;
   logic       turn_a  = 1'b0;
   logic       turn_b  = 1'b0;
   logic       zero_a  = 1'b0;
   logic       zero_b  = 1'b0;
   logic       tick_a, tick_b, add_a, add_b, paused, win_a, win_b;
   logic [1:0] active;
   logic [8:0] dut_vec;

   int n_tests = 0;
   int n_fail  = 0;
   bit started = 1'b0;

   chess_clock_tick_sched #(
      .p_divider(DIV),
      .p_incr   (INC),
      .p_gap    (GAP),
      .p_delay  (DLY)
   ) dut (
      .i_clk_50m(clk),
      .i_rst    (rst),
      .i_restart(restart),
      .i_stop   (stop),
      .i_turn_a (turn_a),
      .i_turn_b (turn_b),
      .i_zero_a (zero_a),
      .i_zero_b (zero_b),
      .o_tick_a (tick_a),
      .o_tick_b (tick_b),
      .o_add_a  (add_a),
      .o_add_b  (add_b),
      .o_active (active),
      .o_paused (paused),
      .o_win_a  (win_a),
      .o_win_b  (win_b)
   );

   always #5 clk = ~clk;

   assign dut_vec = {tick_a, tick_b, add_a, add_b, active, paused, win_a, win_b};

   // ---------------- behavioural model ----------------
   typedef enum {M_IDLE, M_RUN, M_INCR, M_PAUSE, M_OVER} mmode_t;

   typedef struct {
      mmode_t mode;
      int     side;   // 0 = A, 1 = B
      int     run;    // cycles counted in the current turn, frozen while paused
      int     k;      // cycles since bonus burst began
      bit     pend;
      bit     win_a, win_b;
      bit     tick_a, tick_b, add_a, add_b;
   } mstate_t;

   mstate_t m;

   function automatic mstate_t reset_state();
      mstate_t r;
      r.mode = M_IDLE; r.side = 0; r.run = 0; r.k = 0; r.pend = 1'b0;
      r.win_a = 1'b0; r.win_b = 1'b0;
      r.tick_a = 1'b0; r.tick_b = 1'b0; r.add_a = 1'b0; r.add_b = 1'b0;
      return r;
   endfunction

   function automatic mstate_t step(input mstate_t c, input bit r, input bit s,
                                    input bit ta, input bit tb, input bit za, input bit zb);
      mstate_t n;
      bit z, t;
      n = c;
      n.tick_a = 1'b0; n.tick_b = 1'b0; n.add_a = 1'b0; n.add_b = 1'b0;
      z = (c.side == 0) ? za : zb;
      t = (c.side == 0) ? ta : tb;
      if (r) begin
         n.mode = M_IDLE; n.run = 0; n.k = 0; n.pend = 1'b0;
         n.win_a = 1'b0; n.win_b = 1'b0;
      end else begin
         case (c.mode)
            M_IDLE: begin
               if (tb && !ta)      begin n.mode = M_RUN; n.side = 0; n.run = 0; end
               else if (ta && !tb) begin n.mode = M_RUN; n.side = 1; n.run = 0; end
            end
            M_RUN: begin
               if (z) begin
                  n.mode = M_OVER;
                  if (c.side == 0) n.win_b = 1'b1; else n.win_a = 1'b1;
               end else if (s) begin
                  n.mode = M_PAUSE;
               end else if (t) begin
                  n.mode = M_INCR; n.k = 0; n.pend = 1'b0;
               end else begin
                  n.run = c.run + 1;
                  if ((n.run % DIV) == 0 && (n.run / DIV) > DLYN) begin
                     if (c.side == 0) n.tick_a = 1'b1; else n.tick_b = 1'b1;
                  end
               end
            end
            M_INCR: begin
               n.k    = c.k + 1;
               n.pend = c.pend | s;
               if (n.k == INCR_EXIT) begin
                  n.mode = n.pend ? M_PAUSE : M_RUN;
                  n.side = 1 - c.side;
                  n.run  = 0;
                  n.pend = 1'b0;
               end else if (((n.k - 1) % GAP) == 0 && ((n.k - 1) / GAP) < INC) begin
                  if (c.side == 0) n.add_a = 1'b1; else n.add_b = 1'b1;
               end
            end
            M_PAUSE: begin
               if (s) n.mode = M_RUN;
            end
            default: ;
         endcase
      end
      return n;
   endfunction

   function automatic logic [8:0] expect_vec(input mstate_t s);
      logic [1:0] act;
      act = (s.mode == M_RUN) ? ((s.side == 0) ? 2'b01 : 2'b10) : 2'b00;
      return {s.tick_a, s.tick_b, s.add_a, s.add_b, act, s.mode == M_PAUSE, s.win_a, s.win_b};
   endfunction

   // Advance the model on each rising edge; asynchronous reset mirrors the DUT
   always @(posedge clk or negedge rst) begin
      if (!rst) m <= reset_state();
      else      m <= step(m, restart, stop, turn_a, turn_b, zero_a, zero_b);
   end

   // Per-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (started) begin
         n_tests++;
         if (dut_vec !== expect_vec(m)) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t dut=%b model=%b", $time, dut_vec, expect_vec(m));
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check_lit(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic check_vec(input string name, input logic [8:0] want);
      n_tests++;
      if (dut_vec !== want) begin
         n_fail++;
         $display("FAIL %s got=%b want=%b", name, dut_vec, want);
      end
   endtask

   function automatic bit probe(input int sel);
      case (sel)
         0:       return tick_a;
         1:       return tick_b;
         2:       return add_a;
         3:       return add_b;
         4:       return active == 2'b01;
         5:       return active == 2'b10;
         6:       return paused;
         default: return 1'b0;
      endcase
   endfunction

   // Falling edges until the selected event is seen; -1 if the budget expires
   task automatic wait_for(input int sel, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!probe(sel) && n < 200);
      if (!probe(sel)) n = -1;
   endtask

   // 0 restart, 1 stop, 2 turn_a, 3 turn_b, 4 both turns
   task automatic pulse(input int which);
      @(negedge clk);
      case (which)
         0:       restart = 1'b1;
         1:       stop    = 1'b1;
         2:       turn_a  = 1'b1;
         3:       turn_b  = 1'b1;
         default: begin turn_a = 1'b1; turn_b = 1'b1; end
      endcase
      @(negedge clk);
      restart = 1'b0; stop = 1'b0; turn_a = 1'b0; turn_b = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int n, n2, cnt;
      @(posedge clk);
      started = 1'b1;
      repeat (3) @(negedge clk);
      check_vec("reset_outputs", 9'b0);
      rst = 1'b1;

      // start: B's turn-end starts A; ticks every DIV cycles after entry
      pulse(3);
      check_lit("start_active_a", int'(active), 1);
      wait_for(0, n); check_lit("tick_a_first", n, FIRST);
      wait_for(0, n); check_lit("tick_a_second", n, DIV);
      wait_for(0, n); check_lit("tick_a_third", n, DIV);

      // handover with bonus burst
      pulse(2);
      wait_for(2, n);  check_lit("add_a_first", n, 1);
      wait_for(2, n2); check_lit("add_a_second", n + n2, 5);
      wait_for(5, n);  check_lit("handover_active_b", n, 1);
      wait_for(1, n);  check_lit("tick_b_first", n, FIRST);

      // pause at prescaler 6, resume continues from the held count
      pulse(0);
      pulse(3);
      repeat (5) @(negedge clk);
      pulse(1);
      check_lit("paused_level", int'(paused), 1);
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         cnt += int'(tick_a | tick_b);
      end
      check_lit("no_ticks_paused", cnt, 0);
      pulse(1);
      wait_for(0, n); check_lit("tick_after_resume", n, FIRST - 6);

      // zero beats turn in the same cycle
      @(negedge clk);
      zero_a = 1'b1; turn_a = 1'b1;
      @(negedge clk);
      turn_a = 1'b0;
      check_vec("zero_turn_over", 9'b0_0_0_0_00_0_0_1);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         cnt += int'(add_a);
      end
      check_lit("zero_turn_no_add", cnt, 0);
      zero_a = 1'b0;
      pulse(0);
      check_vec("restart_clears", 9'b0);

      // zero already high when the run starts
      @(negedge clk);
      zero_a = 1'b1;
      pulse(3);
      check_lit("zero_entry_active", int'(active), 1);
      @(negedge clk);
      check_vec("zero_entry_over", 9'b0_0_0_0_00_0_0_1);
      zero_a = 1'b0;
      pulse(0);

      // simultaneous turn pulses in IDLE are ignored
      pulse(4);
      repeat (3) @(negedge clk);
      check_vec("both_turns_idle", 9'b0);

      // stop during the burst: both strobes still go out, then pause on side B
      pulse(3);
      pulse(2);
      stop = 1'b1;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) stop = 1'b0;
         cnt += int'(add_a);
      end
      check_lit("incr_stop_adds", cnt, 2);
      check_lit("incr_stop_paused", int'(paused), 1);
      pulse(1);
      check_lit("resume_side_b", int'(active), 2);

      // asynchronous reset in the middle of a burst
      pulse(3);
      wait_for(3, n); check_lit("burst_add_b_first", n, 1);
      #2 rst = 1'b0;
      #1 check_vec("async_reset_mid_burst", 9'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_vec("after_reset_idle", 9'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
